// File: rtl/seg7_scan_pkg.sv
// Shared constants, types and glyph decode for the seven-segment scan receiver.
package seg7_scan_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned NDIG  = 4;
    localparam int unsigned BCD_W = 4;
    localparam int unsigned VAL_W = NDIG * BCD_W;

    // Active-low glyphs, bit order gfedcba
    localparam logic [SEG_W-1:0] GLYPH_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] GLYPH_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] GLYPH_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] GLYPH_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] GLYPH_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] GLYPH_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] GLYPH_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;

    // Active-low one-hot anode codes, digit0 is leftmost
    localparam logic [DIG_W-1:0] DIG0 = 4'b0111;
    localparam logic [DIG_W-1:0] DIG1 = 4'b1011;
    localparam logic [DIG_W-1:0] DIG2 = 4'b1101;
    localparam logic [DIG_W-1:0] DIG3 = 4'b1110;

    typedef enum logic [2:0] {
        SYNC,
        EXP0,
        EXP1,
        EXP2,
        EXP3
    } scan_state_e;

    typedef struct packed {
        logic             bad;
        logic             blank;
        logic [BCD_W-1:0] bcd;
    } glyph_t;

    function automatic glyph_t glyph_decode(input logic [SEG_W-1:0] seg);
        glyph_t g;
        g.bad   = 1'b0;
        g.blank = 1'b0;
        g.bcd   = '0;
        case (seg)
            GLYPH_0:     g.bcd = 4'd0;
            GLYPH_1:     g.bcd = 4'd1;
            GLYPH_2:     g.bcd = 4'd2;
            GLYPH_3:     g.bcd = 4'd3;
            GLYPH_4:     g.bcd = 4'd4;
            GLYPH_5:     g.bcd = 4'd5;
            GLYPH_6:     g.bcd = 4'd6;
            GLYPH_7:     g.bcd = 4'd7;
            GLYPH_8:     g.bcd = 4'd8;
            GLYPH_9:     g.bcd = 4'd9;
            GLYPH_BLANK: g.blank = 1'b1;
            default:     g.bad = 1'b1;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_receiver_if.sv
// Scan bus from the display driver plus the rebuilt display state.
interface seg7_scan_receiver_if;
    import seg7_scan_pkg::*;

    logic [SEG_W-1:0] seg7;
    logic [DIG_W-1:0] dig;
    logic [VAL_W-1:0] dig_val;
    logic [NDIG-1:0]  dig_blank;
    logic [NDIG-1:0]  dig_bad;
    logic [NDIG-1:0]  dig_blink;
    logic             frame_done;
    logic             seq_err;
    logic             scan_err;

    modport master (
        output seg7, dig,
        input  dig_val, dig_blank, dig_bad, dig_blink, frame_done, seq_err, scan_err
    );

    modport slave (
        input  seg7, dig,
        output dig_val, dig_blank, dig_bad, dig_blink, frame_done, seq_err, scan_err
    );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational seven-segment glyph to {bad, blank, bcd} decoder.
module seg7_glyph_decode
    import seg7_scan_pkg::*;
(
    input  logic [SEG_W-1:0] seg7,
    output glyph_t           glyph_c
);

    assign glyph_c = glyph_decode(seg7);

endmodule

// File: rtl/seg7_scan_receiver.sv
// Rebuilds digit values, blank/bad/blink status and framing errors
// from a multiplexed 4-digit seven-segment scan bus.
module seg7_scan_receiver
    import seg7_scan_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 256,
    parameter int unsigned CNT_W         = 9
) (
    input logic                 fast_clk,
    input logic                 rst_n,
    seg7_scan_receiver_if.slave bus
);

    logic [SEG_W-1:0] s1_seg;
    logic [DIG_W-1:0] s1_dig;
    logic             s1_vld;

    logic             idx_ok_c;
    logic [1:0]       idx_c;
    logic [1:0]       exp_idx_c;
    logic             commit_c;
    glyph_t           glyph_c;

    scan_state_e      state_q;
    scan_state_e      state_d;
    logic             frame_done_d;
    logic             seq_err_d;
    logic             scan_err_d;

    logic [BCD_W-1:0] val_q   [NDIG];
    logic             blank_q [NDIG];
    logic             bad_q   [NDIG];
    logic             blink_q [NDIG];

    // Stage 1: capture the bus; a sample taken during reset is never committed
    always_ff @(posedge fast_clk) begin
        s1_seg <= bus.seg7;
        s1_dig <= bus.dig;
        s1_vld <= rst_n;
    end

    seg7_glyph_decode u_glyph_decode (
        .seg7    (s1_seg),
        .glyph_c (glyph_c)
    );

    always_comb begin
        idx_ok_c = 1'b1;
        idx_c    = 2'd0;
        case (s1_dig)
            DIG0:    idx_c = 2'd0;
            DIG1:    idx_c = 2'd1;
            DIG2:    idx_c = 2'd2;
            DIG3:    idx_c = 2'd3;
            default: idx_ok_c = 1'b0;
        endcase
    end

    assign commit_c = s1_vld & idx_ok_c;

    always_comb begin
        exp_idx_c = 2'd0;
        case (state_q)
            EXP1:    exp_idx_c = 2'd1;
            EXP2:    exp_idx_c = 2'd2;
            EXP3:    exp_idx_c = 2'd3;
            default: exp_idx_c = 2'd0;
        endcase
    end

    // Scan-order tracker
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        seq_err_d    = 1'b0;
        scan_err_d   = 1'b0;
        if (s1_vld) begin
            if (!idx_ok_c) begin
                scan_err_d = 1'b1;
                state_d    = SYNC;
            end else if (state_q == SYNC) begin
                if (idx_c == 2'd0) begin
                    state_d = EXP1;
                end
            end else if (idx_c == exp_idx_c) begin
                case (idx_c)
                    2'd0: state_d = EXP1;
                    2'd1: state_d = EXP2;
                    2'd2: state_d = EXP3;
                    default: begin
                        state_d      = EXP0;
                        frame_done_d = 1'b1;
                    end
                endcase
            end else begin
                seq_err_d = 1'b1;
                state_d   = (idx_c == 2'd0) ? EXP1 : SYNC;
            end
        end
    end

    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            state_q        <= SYNC;
            bus.frame_done <= 1'b0;
            bus.seq_err    <= 1'b0;
            bus.scan_err   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus.frame_done <= frame_done_d;
            bus.seq_err    <= seq_err_d;
            bus.scan_err   <= scan_err_d;
        end
    end

    // Per-digit commit and blink detection
    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        logic [CNT_W-1:0] cnt_q;
        logic             prev_blank_q;
        logic             hit_c;

        assign hit_c = commit_c && (idx_c == 2'(i));

        always_ff @(posedge fast_clk) begin
            if (!rst_n) begin
                cnt_q        <= '0;
                prev_blank_q <= 1'b1;
                val_q[i]     <= '0;
                blank_q[i]   <= 1'b1;
                bad_q[i]     <= 1'b0;
                blink_q[i]   <= 1'b0;
            end else if (hit_c) begin
                blank_q[i]   <= glyph_c.blank;
                bad_q[i]     <= glyph_c.bad;
                prev_blank_q <= glyph_c.blank;
                if (!glyph_c.blank && !glyph_c.bad) begin
                    val_q[i] <= glyph_c.bcd;
                end
                if (glyph_c.blank != prev_blank_q) begin
                    blink_q[i] <= 1'b1;
                    cnt_q      <= '0;
                end else if (cnt_q != CNT_W'(STABLE_FRAMES)) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(STABLE_FRAMES - 1)) begin
                        blink_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Digit0 occupies the most significant nibble/bit of each output
    always_comb begin
        bus.dig_val   = '0;
        bus.dig_blank = '0;
        bus.dig_bad   = '0;
        bus.dig_blink = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            bus.dig_val[(NDIG-1-i)*BCD_W +: BCD_W] = val_q[i];
            bus.dig_blank[NDIG-1-i]                = blank_q[i];
            bus.dig_bad[NDIG-1-i]                  = bad_q[i];
            bus.dig_blink[NDIG-1-i]                = blink_q[i];
        end
    end

endmodule

// File: tb/tb_seg7_scan_receiver.sv
// Scoreboard bench for seg7_scan_receiver: directed scan patterns plus random traffic
// checked every cycle against a behavioural display model.
module tb_seg7_scan_receiver;

    logic fast_clk = 1'b0;
    logic rst_n;

    seg7_scan_receiver_if bus ();

    seg7_scan_receiver #(
        .STABLE_FRAMES (256),
        .CNT_W         (9)
    ) dut (
        .fast_clk (fast_clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 fast_clk = ~fast_clk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  blank;
        logic [3:0]  bad;
        logic [3:0]  blink;
        logic        fd;
        logic        se;
        logic        sc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};
    localparam logic [6:0] BL  = 7'b1111111;
    localparam logic [6:0] JNK = 7'b1010101;

    // Behavioural model of what the display is showing
    logic [3:0] m_val   [4];
    bit         m_blank [4];
    bit         m_bad   [4];
    bit         m_blink [4];
    bit         m_prev  [4];
    int         m_cnt   [4];
    int         expect_idx;
    bit         m_fd, m_se, m_sc;
    bit         p_vld;
    logic [6:0] p_seg;
    logic [3:0] p_dig;

    function automatic logic [3:0] dig_of(input int i);
        logic [3:0] t;
        t = 4'b1000;
        return ~(t >> i);
    endfunction

    function automatic void model_commit(input logic [6:0] s, input logic [3:0] d);
        int  idx;
        int  k;
        bit  blank;
        idx = -1;
        if ($countones(~d) == 1)
            for (int i = 0; i < 4; i++)
                if (d[3-i] == 1'b0) idx = i;
        if (idx < 0) begin
            m_sc = 1;
            expect_idx = -1;
            return;
        end
        k = -1;
        for (int j = 0; j < 10; j++)
            if (glyph_tab[j] == s) k = j;
        blank = (s == BL);
        if (expect_idx < 0) begin
            if (idx == 0) expect_idx = 1;
        end else if (idx == expect_idx) begin
            if (idx == 3) begin
                m_fd = 1;
                expect_idx = 0;
            end else begin
                expect_idx = idx + 1;
            end
        end else begin
            m_se = 1;
            expect_idx = (idx == 0) ? 1 : -1;
        end
        m_blank[idx] = blank;
        m_bad[idx]   = (k < 0) && !blank;
        if (k >= 0) m_val[idx] = 4'(k);
        if (blank != m_prev[idx]) begin
            m_blink[idx] = 1;
            m_cnt[idx]   = 0;
        end else begin
            if (m_cnt[idx] < 256) m_cnt[idx]++;
            if (m_cnt[idx] == 256) m_blink[idx] = 0;
        end
        m_prev[idx] = blank;
    endfunction

    function automatic void model_step(input logic [6:0] s, input logic [3:0] d, input logic r);
        exp_t e;
        m_fd = 0;
        m_se = 0;
        m_sc = 0;
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                m_val[i] = 4'd0; m_blank[i] = 1; m_bad[i] = 0;
                m_blink[i] = 0; m_prev[i] = 1; m_cnt[i] = 0;
            end
            expect_idx = -1;
            p_vld = 0;
        end else begin
            if (p_vld) model_commit(p_seg, p_dig);
            p_vld = 1;
            p_seg = s;
            p_dig = d;
        end
        e.val   = {m_val[0], m_val[1], m_val[2], m_val[3]};
        e.blank = {m_blank[0], m_blank[1], m_blank[2], m_blank[3]};
        e.bad   = {m_bad[0], m_bad[1], m_bad[2], m_bad[3]};
        e.blink = {m_blink[0], m_blink[1], m_blink[2], m_blink[3]};
        e.fd    = m_fd;
        e.se    = m_se;
        e.sc    = m_sc;
        q.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs change once per edge, so each edge has one expected snapshot
    initial begin
        exp_t e;
        forever begin
            @(posedge fast_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dig_val",    16'(bus.dig_val),    16'(e.val));
                chk("dig_blank",  16'(bus.dig_blank),  16'(e.blank));
                chk("dig_bad",    16'(bus.dig_bad),    16'(e.bad));
                chk("dig_blink",  16'(bus.dig_blink),  16'(e.blink));
                chk("frame_done", 16'(bus.frame_done), 16'(e.fd));
                chk("seq_err",    16'(bus.seq_err),    16'(e.se));
                chk("scan_err",   16'(bus.scan_err),   16'(e.sc));
            end
        end
    end

    task automatic cycle(input logic [6:0] s, input logic [3:0] d, input logic r);
        bus.seg7 = s;
        bus.dig  = d;
        rst_n    = r;
        @(posedge fast_clk);
        model_step(s, d, r);
        @(negedge fast_clk);
    endtask

    task automatic put(input int n, input logic [6:0] g);
        cycle(g, dig_of(n), 1'b1);
    endtask

    task automatic sweep(input logic [6:0] g0, input logic [6:0] g1,
                         input logic [6:0] g2, input logic [6:0] g3);
        put(0, g0);
        put(1, g1);
        put(2, g2);
        put(3, g3);
    endtask

    initial begin
        logic [6:0] s;
        logic [3:0] d;
        logic       rr;
        int         rsel;
        int         gsel;
        int         ptr;
        bit         lit;

        for (int i = 0; i < 3; i++) cycle(BL, 4'b1111, 1'b0);

        // Steady 1234 display; power-up blink clears after 256 stable frames
        for (int f = 0; f < 300; f++) sweep(glyph_tab[1], glyph_tab[2], glyph_tab[3], glyph_tab[4]);
        chk("steady_val",   16'(bus.dig_val),   16'h1234);
        chk("steady_blank", 16'(bus.dig_blank), 16'h0);
        chk("steady_blink", 16'(bus.dig_blink), 16'h0);

        // Digits 0,1 toggle blank/lit every 100 frames, ending blanked
        for (int f = 0; f < 400; f++) begin
            lit = ((f / 100) % 2) == 0;
            sweep(lit ? glyph_tab[5] : BL, lit ? glyph_tab[6] : BL, glyph_tab[3], glyph_tab[4]);
        end
        chk("blink_on",   16'(bus.dig_blink),     16'hC);
        chk("blink_hold", 16'(bus.dig_val[15:8]), 16'h56);
        chk("blink_bl",   16'(bus.dig_blank),     16'hC);
        for (int f = 0; f < 300; f++) sweep(glyph_tab[5], glyph_tab[6], glyph_tab[3], glyph_tab[4]);
        chk("blink_off", 16'(bus.dig_blink), 16'h0);

        // Out-of-order scan then fresh in-order frames
        put(0, glyph_tab[1]); put(1, glyph_tab[2]); put(3, glyph_tab[4]);
        put(2, glyph_tab[3]); put(3, glyph_tab[4]);
        for (int f = 0; f < 3; f++) sweep(glyph_tab[1], glyph_tab[2], glyph_tab[3], glyph_tab[4]);

        // Illegal anode code mid-sweep
        put(0, glyph_tab[7]); put(1, glyph_tab[8]);
        cycle(glyph_tab[9], 4'b1001, 1'b1);
        put(2, glyph_tab[9]); put(3, glyph_tab[0]);
        for (int f = 0; f < 2; f++) sweep(glyph_tab[1], glyph_tab[2], glyph_tab[3], glyph_tab[4]);

        // Undecodable glyph on digit2
        sweep(glyph_tab[1], glyph_tab[2], JNK, glyph_tab[4]);
        chk("bad_flag", 16'(bus.dig_bad),      16'h2);
        chk("bad_hold", 16'(bus.dig_val[7:4]), 16'h3);
        sweep(glyph_tab[1], glyph_tab[2], glyph_tab[3], glyph_tab[4]);

        // Reset while expecting index2, then resume mid-frame
        put(0, glyph_tab[1]); put(1, glyph_tab[2]);
        cycle(glyph_tab[3], dig_of(2), 1'b0);
        put(1, glyph_tab[2]); put(2, glyph_tab[3]); put(3, glyph_tab[4]);
        for (int f = 0; f < 2; f++) sweep(glyph_tab[1], glyph_tab[2], glyph_tab[3], glyph_tab[4]);

        // Random traffic: mostly in-order scans with glitches, misorders and resets
        ptr = 0;
        for (int n = 0; n < 3000; n++) begin
            rsel = int'($urandom_range(0, 99));
            gsel = int'($urandom_range(0, 99));
            if (gsel < 70)      s = glyph_tab[$urandom_range(0, 9)];
            else if (gsel < 85) s = BL;
            else                s = 7'($urandom);
            rr = (rsel == 0) ? 1'b0 : 1'b1;
            if (rsel < 5) begin
                d = 4'($urandom);
            end else if (rsel < 12) begin
                d = dig_of(int'($urandom_range(0, 3)));
            end else begin
                d = dig_of(ptr);
                ptr = (ptr + 1) % 4;
            end
            cycle(s, d, rr);
        end

        for (int i = 0; i < 3; i++) sweep(glyph_tab[1], glyph_tab[2], glyph_tab[3], glyph_tab[4]);
        @(posedge fast_clk);
        #2;
        chk("queue_drain", 16'(q.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
